dcache_mshr: RTL

Miss-status holding register for the data cache. It sits directly downstream of `dcache`: it accepts cache misses, merges misses to the same address, and issues one memory read per distinct address. It returns each fill with a mask of every consumer waiting on that address, so the cache can install the block and answer all of them in one cycle.

---
 rtl/dcache_mshr.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_mshr.sv
// Miss-status holding register: merges same-address cache misses, issues one memory read per
// distinct address, and returns each fill together with the mask of every waiting consumer.
module dcache_mshr #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_ENTRIES   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               miss_valid,
    input  logic [ADDR_BITS-1:0]               miss_address,
    input  logic [$clog2(NUM_CONSUMERS)-1:0]   miss_consumer,
    output logic                               miss_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               fill_valid,
    output logic [ADDR_BITS-1:0]               fill_address,
    output logic [DATA_BITS-1:0]               fill_data,
    output logic [NUM_CONSUMERS-1:0]           fill_mask,
    output logic [$clog2(NUM_ENTRIES):0]       occupancy
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int OCC_W = $clog2(NUM_ENTRIES) + 1;

    typedef enum logic [1:0] {
        ST_FREE,
        ST_PENDING,
        ST_ISSUED,
        ST_FILL
    } entry_state_e;

    entry_state_e             state_q [NUM_ENTRIES];
    entry_state_e             state_d [NUM_ENTRIES];
    logic [ADDR_BITS-1:0]     addr_q  [NUM_ENTRIES];
    logic [ADDR_BITS-1:0]     addr_d  [NUM_ENTRIES];
    logic [NUM_CONSUMERS-1:0] mask_q  [NUM_ENTRIES];
    logic [NUM_CONSUMERS-1:0] mask_d  [NUM_ENTRIES];

    logic                     mem_read_valid_q,   mem_read_valid_d;
    logic [ADDR_BITS-1:0]     mem_read_address_q, mem_read_address_d;
    logic                     fill_valid_q,       fill_valid_d;
    logic [ADDR_BITS-1:0]     fill_address_q,     fill_address_d;
    logic [DATA_BITS-1:0]     fill_data_q,        fill_data_d;
    logic [NUM_CONSUMERS-1:0] fill_mask_q,        fill_mask_d;
    logic [OCC_W-1:0]         occupancy_q,        occupancy_d;

    logic             hit_live, hit_fill, free_found, pend_found, issued_found;
    logic [IDX_W-1:0] hit_idx, free_idx, pend_idx, issued_idx;
    logic             accept;
    logic [NUM_CONSUMERS-1:0] consumer_bit;

    // Scanning from the top down lets the lowest matching index win each search.
    // NOTE: every always_comb output gets a default before any branch, so no latches are inferred.
    always_comb begin
        hit_live     = 1'b0;
        hit_fill     = 1'b0;
        free_found   = 1'b0;
        pend_found   = 1'b0;
        issued_found = 1'b0;
        hit_idx      = '0;
        free_idx     = '0;
        pend_idx     = '0;
        issued_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (addr_q[i] == miss_address &&
                (state_q[i] == ST_PENDING || state_q[i] == ST_ISSUED)) begin
                hit_live = 1'b1;
                hit_idx  = IDX_W'(i);
            end
            if (addr_q[i] == miss_address && state_q[i] == ST_FILL) begin
                hit_fill = 1'b1;
            end
            if (state_q[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (state_q[i] == ST_PENDING) begin
                pend_found = 1'b1;
                pend_idx   = IDX_W'(i);
            end
            if (state_q[i] == ST_ISSUED) begin
                issued_found = 1'b1;
                issued_idx   = IDX_W'(i);
            end
        end
    end

    assign miss_ready   = hit_live || (!hit_fill && free_found);
    assign accept       = miss_valid && miss_ready;
    assign consumer_bit = NUM_CONSUMERS'(1) << miss_consumer;

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        mask_d             = mask_q;
        mem_read_valid_d   = mem_read_valid_q;
        mem_read_address_d = mem_read_address_q;
        fill_valid_d       = 1'b0;
        fill_address_d     = fill_address_q;
        fill_data_d        = fill_data_q;
        fill_mask_d        = fill_mask_q;
        occupancy_d        = '0;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (state_q[i] == ST_FILL) state_d[i] = ST_FREE;
        end

        if (accept) begin
            if (hit_live) begin
                mask_d[hit_idx] = mask_q[hit_idx] | consumer_bit;
            end else begin
                state_d[free_idx] = ST_PENDING;
                addr_d[free_idx]  = miss_address;
                mask_d[free_idx]  = consumer_bit;
            end
        end

        // The mask is read after the merge so a waiter arriving on the response edge is included.
        if (mem_read_valid_q && mem_read_ready) begin
            mem_read_valid_d    = 1'b0;
            state_d[issued_idx] = ST_FILL;
            fill_valid_d        = 1'b1;
            fill_address_d      = addr_q[issued_idx];
            fill_data_d         = mem_read_data;
            fill_mask_d         = mask_d[issued_idx];
        end

        // Issue looks only at start-of-cycle state, so a fresh allocation waits one cycle.
        if (!issued_found && !mem_read_valid_q && pend_found) begin
            state_d[pend_idx]  = ST_ISSUED;
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = addr_q[pend_idx];
        end

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (state_d[i] != ST_FREE) occupancy_d = occupancy_d + OCC_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= ST_FREE;
                addr_q[i]  <= '0;
                mask_q[i]  <= '0;
            end
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            fill_valid_q       <= 1'b0;
            fill_address_q     <= '0;
            fill_data_q        <= '0;
            fill_mask_q        <= '0;
            occupancy_q        <= '0;
        end else begin
            state_q            <= state_d;
            addr_q             <= addr_d;
            mask_q             <= mask_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_read_address_q <= mem_read_address_d;
            fill_valid_q       <= fill_valid_d;
            fill_address_q     <= fill_address_d;
            fill_data_q        <= fill_data_d;
            fill_mask_q        <= fill_mask_d;
            occupancy_q        <= occupancy_d;
        end
    end

    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;
    assign fill_valid       = fill_valid_q;
    assign fill_address     = fill_address_q;
    assign fill_data        = fill_data_q;
    assign fill_mask        = fill_mask_q;
    assign occupancy        = occupancy_q;

endmodule
